mult_datapath: RTL
==================

MULT_DATAPATH -- requirements
Module: mult_datapath

Interface
REQ-001 SHALL have reset rst, asynchronous, active-high; clock clk.
REQ-002 SHALL have ports, one per line (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  async active-high reset
- wrctrl  in  1  load operands, start sequence
- addctrl  in  6  ALU function code; 6'd27 = add, 6'd0 = idle
- strctrl  in  1  store registered ALU sum into product upper half
- multiplicand_in  in  32  multiplicand operand
- multiplier_in  in  32  multiplier operand
- lsb  out  1  product[0], to controller
- product  out  64  product register
- busy  out  1  iteration sequence in progress
- done  out  1  32 shifts complete; held until next load or reset
- err  out  1  sticky protocol-error flag

Function
REQ-003 All control inputs SHALL be sampled on the rising clk edge; no combinational path from control inputs to outputs.
REQ-004 On a wrctrl edge, SHALL load mcand<=multiplicand_in and product<={32'b0, multiplier_in}, and clear shift_cnt, phase, sum_reg, pend, done; set busy.
REQ-005 wrctrl while busy SHALL abort and restart with new operands; err unchanged.
REQ-006 lsb SHALL equal product[0] at all times.
REQ-007 On an edge with busy and addctrl==27, SHALL register {carry,sum}<=product[63:32]+mcand (33-bit) and set pend.
REQ-008 A nonzero addctrl other than 27 SHALL be ignored and set err.
REQ-009 Internal phase counter (0..2) SHALL reset to 0 on load and advance by 1 mod 3 on every busy edge; the edge at which phase==2 is a shift edge.
REQ-010 On a shift edge with strctrl==1 and pend==1: product<={carry, sum, product[31:1]}; pend cleared.
REQ-011 On a shift edge with strctrl==0: product<={1'b0, product[63:1]}.
REQ-012 strctrl with pend==0, or strctrl on a non-shift edge, SHALL set err; on a shift edge, plain shift per REQ-011.
REQ-013 A pend still set at a shift edge without strctrl SHALL be discarded and SHALL set err.
REQ-014 Each shift edge SHALL increment the 6-bit shift_cnt; the 32nd shift edge SHALL clear busy and set done in the same edge.
REQ-015 With busy==0, addctrl/strctrl SHALL NOT modify product; strctrl still sets err.
REQ-016 Per-iteration timing: first shift edge is the 3rd edge after the load edge; subsequent shifts every 3 edges; done at the 96th edge after load.
REQ-017 Result SHALL be the unsigned 64-bit product of the operands; carry-out of each add SHALL be preserved in bit 63 before the shift.

Reset
REQ-018 rst SHALL asynchronously clear product, mcand, sum_reg, carry, pend, phase, shift_cnt, busy, done, err to 0.
REQ-019 rst mid-sequence SHALL abandon the operation; no output retains partial state.
REQ-020 err SHALL clear only on rst.

Structure
REQ-021 Shared package SHALL hold WIDTH=32, ITER=32, ALU_ADD=6'd27, ALU_NOP=6'd0.
REQ-022 A 32-bit adder with carry-out SHALL be a separate sub-module, mult_adder; all registers stay in mult_datapath.

Verification
REQ-023 Load 3 x 5, drive the controller-accurate pattern (addctrl on phase-1 edges and strctrl on the following shift edge when lsb=1) -> product=64'd15, done at edge 96, err=0.
REQ-024 Load 0xFFFFFFFF x 0xFFFFFFFF -> product=64'hFFFFFFFE00000001, carry preserved every step, err=0.
REQ-025 Load 0 x 0x12345678, no addctrl/strctrl -> product=0 after 32 shifts, done=1, lsb=0 throughout.
REQ-026 Assert rst at edge 40 of a 7 x 9 run -> all outputs 0 immediately; then a new load of 7 x 9 -> 64'd63.
REQ-027 Assert wrctrl with 2 x 4 at edge 20 of a 7 x 9 run -> restart, result 64'd8 at edge 96 after the second load.
REQ-028 strctrl with no prior add, then addctrl=6'd5 -> err=1 and stays set until rst; product follows REQ-011.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared constants and types for the shift-and-add multiplier datapath.
package mult_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = 32;
    localparam int CNT_W = 6;

    localparam logic [5:0]       ALU_ADD    = 6'd27;
    localparam logic [5:0]       ALU_NOP    = 6'd0;
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(ITER - 1);

    typedef enum logic [1:0] {
        PH_0 = 2'd0,
        PH_1 = 2'd1,
        PH_2 = 2'd2
    } phase_t;

    function automatic phase_t next_phase(input phase_t p);
        case (p)
            PH_0:    return PH_1;
            PH_1:    return PH_2;
            default: return PH_0;
        endcase
    endfunction

endpackage

// File: rtl/mult_adder.sv
// Combinational WIDTH-bit adder with carry-out feeding the product upper half.
import mult_pkg::*;

module mult_adder (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/mult_datapath.sv
// Sequential shift-and-add multiplier datapath; a separate controller issues
// add/store strobes on a three-edge phase rhythm and watches lsb.
import mult_pkg::*;

module mult_datapath (
    input  logic               clk,
    input  logic               rst,
    input  logic               wrctrl,
    input  logic [5:0]         addctrl,
    input  logic               strctrl,
    input  logic [WIDTH-1:0]   multiplicand_in,
    input  logic [WIDTH-1:0]   multiplier_in,
    output logic               lsb,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done,
    output logic               err
);

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               pend_q, pend_d;
    phase_t             phase_q, phase_d;
    logic [CNT_W-1:0]   shift_cnt_q, shift_cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic               shift_edge;

    mult_adder u_adder (
        .a    (product_q[2*WIDTH-1:WIDTH]),
        .b    (mcand_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign shift_edge = busy_q && (phase_q == PH_2);

    always_comb begin
        // NOTE: every _d gets its hold value first so no path can infer a latch.
        mcand_d     = mcand_q;
        product_d   = product_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        pend_d      = pend_q;
        phase_d     = phase_q;
        shift_cnt_d = shift_cnt_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;

        if (wrctrl) begin
            // A load (or restart) wins over any strobe on the same edge.
            mcand_d     = multiplicand_in;
            product_d   = {{WIDTH{1'b0}}, multiplier_in};
            sum_d       = '0;
            carry_d     = 1'b0;
            pend_d      = 1'b0;
            phase_d     = PH_0;
            shift_cnt_d = '0;
            busy_d      = 1'b1;
            done_d      = 1'b0;
        end else begin
            if (addctrl != ALU_ADD && addctrl != ALU_NOP)
                err_d = 1'b1;
            if (strctrl && (!shift_edge || !pend_q))
                err_d = 1'b1;
            if (shift_edge && pend_q && !strctrl)
                err_d = 1'b1;

            if (busy_q) begin
                phase_d = next_phase(phase_q);
                if (shift_edge) begin
                    if (strctrl && pend_q)
                        product_d = {carry_q, sum_q, product_q[WIDTH-1:1]};
                    else
                        product_d = {1'b0, product_q[2*WIDTH-1:1]};
                    pend_d      = 1'b0;
                    shift_cnt_d = shift_cnt_q + CNT_W'(1);
                    if (shift_cnt_q == LAST_SHIFT) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end
                end
                if (addctrl == ALU_ADD) begin
                    sum_d   = add_sum;
                    carry_d = add_cout;
                    pend_d  = 1'b1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q     <= '0;
            product_q   <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            pend_q      <= 1'b0;
            phase_q     <= PH_0;
            shift_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mcand_q     <= mcand_d;
            product_q   <= product_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            pend_q      <= pend_d;
            phase_q     <= phase_d;
            shift_cnt_q <= shift_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign lsb     = product_q[0];
    assign product = product_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule
